// File: rtl/cell_test_pkg.sv
// cell_test_pkg: cell encodings, FSM states and truth-table helpers for cell_vector_tester
package cell_test_pkg;
    localparam logic [3:0] CELL_AND2  = 4'd0;
    localparam logic [3:0] CELL_OR2   = 4'd1;
    localparam logic [3:0] CELL_NOR2  = 4'd2;
    localparam logic [3:0] CELL_INV   = 4'd3;
    localparam logic [3:0] CELL_BUF   = 4'd4;
    localparam logic [3:0] CELL_AOI21 = 4'd5;
    localparam logic [3:0] CELL_LAST  = CELL_AOI21;

    typedef enum logic [2:0] {ST_IDLE, ST_APPLY, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    function automatic logic [3:0] nvec(input logic [3:0] sel);
        return (sel == CELL_INV || sel == CELL_BUF) ? 4'd2 : (sel == CELL_AOI21) ? 4'd8 : 4'd4;
    endfunction

    function automatic logic exp_y(input logic [3:0] sel, input logic a, input logic b, input logic c);
        return (sel == CELL_AND2)  ? (a & b) :
               (sel == CELL_OR2)   ? (a | b) :
               (sel == CELL_NOR2)  ? ~(a | b) :
               (sel == CELL_INV)   ? ~a :
               (sel == CELL_BUF)   ? a :
               (sel == CELL_AOI21) ? ~((a & b) | c) : 1'b0;
    endfunction
endpackage

// File: rtl/cell_y_sync.sv
// cell_y_sync: 2-FF synchronizer for the asynchronous cell Y output
module cell_y_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= 1'b0;
            q <= 1'b0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/cell_vector_tester.sv
// cell_vector_tester: exhaustive stimulus/response sequencer for the standard-cell test array
// Optional first-failure log enabled by CELL_TEST_FAILLOG_EN.
module cell_vector_tester
    import cell_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [3:0]       cell_sel_i,
    input  logic [7:0]       npass_i,
    input  logic             y_i,
    output logic [2:0]       stim_o,
    output logic [3:0]       sel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             bad_sel_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             fail_valid_o,
    output logic [2:0]       fail_vec_o,
    output logic [7:0]       fail_pass_o
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t          state;
    logic [7:0]      npass_q;
    logic [7:0]      pcnt;
    logic [CW-1:0]   scnt;
    logic            y_sync;
    logic            last;
    logic            mism;
    logic            fin;
    logic [7:0]      pinc;

    cell_y_sync u_sync (.clk(wb_clk_i), .rst_n(wb_rstn_i), .d(y_i), .q(y_sync));

    // stim_o doubles as the vector index: it is 0 whenever a run starts
    always_comb begin
        last = ({1'b0, stim_o} == nvec(sel_o) - 4'd1);
        mism = (y_sync != exp_y(sel_o, stim_o[0], stim_o[1], stim_o[2]));
        pinc = (pcnt == 8'hff) ? pcnt : pcnt + 8'd1;
        fin  = stop_i || (npass_q != 8'd0 && last && ({1'b0, pcnt} + 9'd1 == {1'b0, npass_q}));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state     <= ST_IDLE;
            stim_o    <= 3'd0;
            sel_o     <= 4'd0;
            npass_q   <= 8'd0;
            pcnt      <= 8'd0;
            scnt      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            bad_sel_o <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
                    sel_o     <= cell_sel_i;
                    npass_q   <= npass_i;
                    pcnt      <= 8'd0;
                    stim_o    <= 3'd0;
                    err_cnt_o <= '0;
                    pass_o    <= 1'b0;
                    bad_sel_o <= (cell_sel_i > CELL_LAST);
                    busy_o    <= 1'b1;
                    state     <= ST_APPLY;
                end
                // an invalid selection leaves from the first APPLY cycle with stim held at 0
                ST_APPLY: begin
                    scnt   <= '0;
                    state  <= bad_sel_o ? ST_DONE : ST_SETTLE;
                    done_o <= bad_sel_o;
                end
                ST_SETTLE: begin
                    scnt  <= scnt + 1'b1;
                    state <= (scnt == CW'(SETTLE_CYCLES - 1)) ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SAMPLE: begin
                    if (mism && !(&err_cnt_o))
                        err_cnt_o <= err_cnt_o + 1'b1;
                    pcnt   <= last ? pinc : pcnt;
                    stim_o <= (fin || last) ? 3'd0 : stim_o + 3'd1;
                    state  <= fin ? ST_DONE : ST_APPLY;
                    done_o <= fin;
                    pass_o <= fin && err_cnt_o == '0 && !mism;
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CELL_TEST_FAILLOG_EN
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            fail_valid_o <= 1'b0;
            fail_vec_o   <= 3'd0;
            fail_pass_o  <= 8'd0;
        end else if (state == ST_IDLE && start_i) begin
            fail_valid_o <= 1'b0;
            fail_vec_o   <= 3'd0;
            fail_pass_o  <= 8'd0;
        end else if (state == ST_SAMPLE && mism && !fail_valid_o) begin
            fail_valid_o <= 1'b1;
            fail_vec_o   <= stim_o;
            fail_pass_o  <= pcnt;
        end
    end
`else
    assign fail_valid_o = 1'b0;
    assign fail_vec_o   = 3'd0;
    assign fail_pass_o  = 8'd0;
`endif
endmodule

// File: tb/tb_cell_vector_tester.sv
// tb_cell_vector_tester: table-driven check of cell_vector_tester with a behavioural cell model
module tb_cell_vector_tester;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] sel_in = 4'd0;
    logic [7:0] np_in = 8'd0;
    logic       y;
    logic [2:0] stim;
    logic [3:0] sel_o;
    logic       busy, done, pass, bad;
    logic [1:0] err;
    logic       fvalid;
    logic [2:0] fvec;
    logic [7:0] fpass;

    int mode = 0;
    int errors = 0;
    int checks = 0;
    logic [2:0] seq [8];

    cell_vector_tester #(.SETTLE_CYCLES(4), .ERR_W(2)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start_i(start), .stop_i(stop),
        .cell_sel_i(sel_in), .npass_i(np_in), .y_i(y), .stim_o(stim), .sel_o(sel_o),
        .busy_o(busy), .done_o(done), .pass_o(pass), .bad_sel_o(bad), .err_cnt_o(err),
        .fail_valid_o(fvalid), .fail_vec_o(fvec), .fail_pass_o(fpass)
    );

    always #5 clk = ~clk;

    function automatic logic model(input logic [3:0] s, input logic [2:0] x);
        logic a, b, c;
        {c, b, a} = x;
        case (s)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return !(a | b);
            4'd3: return !a;
            4'd4: return a;
            4'd5: return !((a & b) | c);
            default: return 1'b0;
        endcase
    endfunction

    // mode 0 ideal, 1 stuck at 0, 2 inverted
    assign y = (mode == 0) ? model(sel_o, stim) : (mode == 1) ? 1'b0 : !model(sel_o, stim);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [3:0] s, input logic [7:0] n);
        @(negedge clk);
        sel_in = s;
        np_in  = n;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // sample k follows the k-th edge after the acceptance edge
    task automatic wait_done(input int maxk, input int mk, input int md, output int kd);
        kd = -1;
        for (int k = 0; k <= maxk; k++) begin
            if (k == mk) mode = md;
            if (k % 6 == 0 && k / 6 < 8) seq[k / 6] = stim;
            if (done) begin
                kd = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] sel;
        logic [7:0] np;
        int md;
        int mk;
        int edges;
        int err;
        int pass;
        int bad;
        int fvec;
        int fpass;
        int nv;
    } vec_t;

    vec_t tv [10];

    initial begin
        int kd, ndone;
        tv[0] = '{4'd0, 8'd1, 0, -1, 25, 0, 1, 0, 0, 0, 4};
        tv[1] = '{4'd3, 8'd3, 1, 0, 37, 3, 0, 0, 0, 0, 2};
        tv[2] = '{4'd9, 8'd5, 0, -1, 2, 0, 0, 1, 0, 0, 0};
        tv[3] = '{4'd2, 8'd4, 2, 0, 97, 3, 0, 0, 0, 0, 4};
        tv[4] = '{4'd1, 8'd2, 0, -1, 49, 0, 1, 0, 0, 0, 4};
        tv[5] = '{4'd4, 8'd1, 1, 0, 13, 1, 0, 0, 1, 0, 2};
        tv[6] = '{4'd5, 8'd1, 1, 0, 49, 3, 0, 0, 0, 0, 8};
        tv[7] = '{4'd0, 8'd3, 2, 24, 73, 3, 0, 0, 0, 1, 4};
        tv[8] = '{4'd15, 8'd1, 0, -1, 2, 0, 0, 1, 0, 0, 0};
        tv[9] = '{4'd6, 8'd0, 0, -1, 2, 0, 0, 1, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_bad", bad, 0);
        chk("reset_err", err, 0);
        chk("reset_stim", stim, 0);
        chk("reset_sel", sel_o, 0);
        chk("reset_fail", {fvalid, fvec, fpass}, 0);
        rst_n = 1'b1;

        stop = 1'b1;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ndone += done + busy;
        end
        stop = 1'b0;
        chk("idle_stop_no_effect", ndone, 0);

        foreach (tv[i]) begin
            mode = 0;
            launch(tv[i].sel, tv[i].np);
            chk($sformatf("v%0d_busy_start", i), busy, 1);
            wait_done(200, tv[i].mk, tv[i].md, kd);
            chk($sformatf("v%0d_edges", i), kd + 1, tv[i].edges);
            chk($sformatf("v%0d_err", i), err, tv[i].err);
            chk($sformatf("v%0d_pass", i), pass, tv[i].pass);
            chk($sformatf("v%0d_bad", i), bad, tv[i].bad);
`ifdef CELL_TEST_FAILLOG_EN
            chk($sformatf("v%0d_fvalid", i), fvalid, (tv[i].err != 0) ? 1 : 0);
            chk($sformatf("v%0d_fvec", i), fvec, tv[i].fvec);
            chk($sformatf("v%0d_fpass", i), fpass, tv[i].fpass);
`else
            chk($sformatf("v%0d_fail_tied", i), {fvalid, fvec, fpass}, 0);
`endif
            if (tv[i].bad == 0)
                for (int j = 0; j < 8 && j < tv[i].np * tv[i].nv; j++)
                    chk($sformatf("v%0d_stim%0d", i, j), seq[j], j % tv[i].nv);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
            chk($sformatf("v%0d_stim_idle", i), stim, 0);
            chk($sformatf("v%0d_pass_hold", i), pass, tv[i].pass);
        end
        mode = 0;

        // AOI21 free-running, stop during vector 5 of pass 2 (zero-based)
        launch(4'd5, 8'd0);
        kd = -1;
        for (int k = 0; k <= 400; k++) begin
            if (k == 128) stop = 1'b1;
            if (done) begin
                kd = k;
                break;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        chk("stop_done_k", kd, 132);
        chk("stop_err", err, 0);
        chk("stop_pass", pass, 1);
        @(negedge clk);
        chk("stop_stim_idle", stim, 0);
        chk("stop_busy", busy, 0);

        // stop arriving with the final vector gives one DONE; a start while busy is ignored
        launch(4'd0, 8'd1);
        ndone = 0;
        kd = -1;
        for (int k = 0; k <= 30; k++) begin
            if (k == 3) begin
                sel_in = 4'd3;
                start  = 1'b1;
            end
            if (k == 4) start = 1'b0;
            if (k == 20) stop = 1'b1;
            if (done) begin
                ndone++;
                if (kd < 0) kd = k;
            end
            @(negedge clk);
        end
        stop = 1'b0;
        chk("sim_stop_ndone", ndone, 1);
        chk("sim_stop_k", kd, 24);
        chk("busy_start_sel", sel_o, 0);
        chk("sim_stop_pass", pass, 1);

        // asynchronous reset in the middle of SETTLE
        mode = 2;
        launch(4'd1, 8'd2);
        repeat (10) @(negedge clk);
        chk("pre_rst_err", err, 1);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_stim", stim, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_other", {done, pass, bad, fvalid, fvec, fpass}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        launch(4'd0, 8'd1);
        wait_done(200, -1, 0, kd);
        chk("post_rst_edges", kd + 1, 25);
        chk("post_rst_err", err, 0);
        chk("post_rst_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
